ternary_array_sequencer: RTL and testbench
==========================================

Name: ternary_array_sequencer

Overview:
Control FSM that runs one complete tile job on ternary_systolic_array_int (N×N, weight-stationary).
- Loads the N weight rows from the weight buffer.
- Streams num_vec activation vectors from the activation buffer.
- Drains the array's pipeline and flags which south-edge cycles carry valid results.
- Sits between the TPU command decoder (start/done) and the array plus its operand buffers.

Parameters:
ARRAY_SIZE, 8, array dimension N (power of 2, ≥2)
ADDR_W, 12, weight/activation buffer address width
VEC_W, 10, width of the vector count and result index
PIPE_LAT, 9, enabled cycles from a vector entering column 0 until its column-0 result appears on the south edge

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  job request; sampled only in IDLE
abort  in  1  cancel the current job
stall  in  1  downstream backpressure; freezes COMPUTE/DRAIN
num_vec  in  VEC_W  number of activation vectors; latched on start
wbase  in  ADDR_W  weight buffer base address; latched on start
abase  in  ADDR_W  activation buffer base address; latched on start
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
wbuf_rd_en  out  1  weight buffer read strobe (1-cycle read latency)
wbuf_rd_addr  out  ADDR_W  weight row address
arr_weight_load  out  1  to array weight_load
arr_weight_row  out  $clog2(ARRAY_SIZE)  to array weight_row
act_rd_en  out  1  activation buffer read (combinational buffer; data valid same cycle)
act_rd_addr  out  ADDR_W  activation vector address
arr_enable  out  1  to array enable
res_valid  out  1  column-0 south-edge output holds a valid result
res_idx  out  VEC_W  vector index of the current result

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; counters and latched config 0.
- States:
  - IDLE → LOAD_W on start.
  - LOAD_W → COMPUTE after N+1 cycles, or → DONE directly when num_vec=0.
  - COMPUTE → DRAIN after num_vec issued vectors.
  - DRAIN → DONE after PIPE_LAT+N-1 enabled cycles.
  - DONE → IDLE after 1 cycle.
- On start in IDLE: latch num_vec, wbase and abase. Cycle 0 is the first cycle in LOAD_W. busy=1 in every state except IDLE and DONE.
- LOAD_W, cycle k:
  - For k=0..N-1: wbuf_rd_en=1, wbuf_rd_addr=wbase+k.
  - For k=1..N: arr_weight_load=1, arr_weight_row=k-1.
  - stall is ignored in LOAD_W.
- COMPUTE:
  - Each cycle with stall=0: act_rd_en=1, act_rd_addr=abase+v, arr_enable=1, then v++.
  - On stall=1: act_rd_en=0, arr_enable=0, and v and act_rd_addr hold.
- DRAIN: arr_enable=~stall; act_rd_en=0.
- Enabled-cycle counter ecnt: counts arr_enable=1 cycles from the first COMPUTE cycle.
  - res_valid=1 on an enabled cycle when PIPE_LAT ≤ ecnt ≤ PIPE_LAT+num_vec-1.
  - res_idx = ecnt-PIPE_LAT on those cycles; res_valid=0 and res_idx=0 otherwise, including stalled cycles.
  - Downstream deskews column c by c cycles.
- Total enabled cycles per job = num_vec+PIPE_LAT+N-1. The DRAIN→DONE transition follows the last enabled cycle.
- DONE: done=1, busy=0, all other outputs 0.
- abort (any non-IDLE state): next cycle IDLE, all outputs 0, no done pulse. abort has priority over stall and over state transitions.
- start: ignored when not in IDLE (including DONE). If start and abort are both asserted in IDLE, start wins.
- Address wrap: wbase+k and abase+v wrap modulo 2^ADDR_W.
- num_vec=0: LOAD_W still performs the full weight load, then DONE at cycle N+1; no act reads, no res_valid.

Test Plan:
1. Reset: assert rst mid-job (cycle 12) → same cycle, all outputs 0, busy=0; after release, no activity until start.
2. N=8, PIPE_LAT=9, num_vec=4, wbase=0x010, abase=0x040 →
   - wbuf_rd_addr 0x010..0x017 at cycles 0–7; arr_weight_load rows 0..7 at cycles 1–8.
   - act_rd_addr 0x040..0x043 at cycles 9–12; arr_enable at cycles 9–28.
   - res_valid at cycles 18–21 with res_idx 0..3; done at cycle 29.
3. Same job as scenario 2 with stall=1 at cycles 10–12 → act_rd_addr holds 0x041; arr_enable and res_valid low for those cycles; res_valid at cycles 21–24; done at cycle 32.
4. abort at cycle 20 of scenario 2 → cycle 21: IDLE, arr_enable=0, res_valid=0; done never pulses; a new start is accepted at cycle 21.
5. num_vec=0, wbase=0xFFE → wbuf_rd_addr 0xFFE, 0xFFF, 0x000..0x005 (wrap); no act_rd_en; done at cycle 9.
6. start pulsed at cycles 5 and 29 (DONE) of scenario 2 → both ignored; no job restart, busy=0 from cycle 29.

Source files
------------

// File: rtl/ternary_array_sequencer.sv
// Tile-job sequencer for the weight-stationary ternary systolic array:
// weight load, activation streaming, pipeline drain and result tagging.
module ternary_array_sequencer #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned VEC_W      = 10,
    parameter int unsigned PIPE_LAT   = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          stall,
    input  logic [VEC_W-1:0]              num_vec,
    input  logic [ADDR_W-1:0]             wbase,
    input  logic [ADDR_W-1:0]             abase,
    output logic                          busy,
    output logic                          done,
    output logic                          wbuf_rd_en,
    output logic [ADDR_W-1:0]             wbuf_rd_addr,
    output logic                          arr_weight_load,
    output logic [$clog2(ARRAY_SIZE)-1:0] arr_weight_row,
    output logic                          act_rd_en,
    output logic [ADDR_W-1:0]             act_rd_addr,
    output logic                          arr_enable,
    output logic                          res_valid,
    output logic [VEC_W-1:0]              res_idx
);

    localparam int unsigned ROW_W  = $clog2(ARRAY_SIZE);
    localparam int unsigned CNT_W  = ROW_W + 1;
    localparam int unsigned ECNT_W = VEC_W + 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VEC_W-1:0]  v_q, v_d;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d;
    logic [VEC_W-1:0]  num_vec_q, num_vec_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;
    logic [ADDR_W-1:0] abase_q, abase_d;

    logic [ECNT_W-1:0] res_first;
    logic [ECNT_W-1:0] res_last;
    logic [ECNT_W-1:0] ecnt_last;
    logic              en;

    assign res_first = ECNT_W'(PIPE_LAT);
    assign res_last  = ECNT_W'(PIPE_LAT) + ECNT_W'(num_vec_q) - ECNT_W'(1);
    assign ecnt_last = ECNT_W'(num_vec_q) + ECNT_W'(PIPE_LAT + ARRAY_SIZE - 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            v_q       <= '0;
            ecnt_q    <= '0;
            num_vec_q <= '0;
            wbase_q   <= '0;
            abase_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            v_q       <= v_d;
            ecnt_q    <= ecnt_d;
            num_vec_q <= num_vec_d;
            wbase_q   <= wbase_d;
            abase_q   <= abase_d;
        end
    end

    // Next-state and outputs; stall gates the enable within the same cycle.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        v_d             = v_q;
        ecnt_d          = ecnt_q;
        num_vec_d       = num_vec_q;
        wbase_d         = wbase_q;
        abase_d         = abase_q;
        en              = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        wbuf_rd_en      = 1'b0;
        wbuf_rd_addr    = '0;
        arr_weight_load = 1'b0;
        arr_weight_row  = '0;
        act_rd_en       = 1'b0;
        act_rd_addr     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD_W;
                    cnt_d     = '0;
                    v_d       = '0;
                    ecnt_d    = '0;
                    num_vec_d = num_vec;
                    wbase_d   = wbase;
                    abase_d   = abase;
                end
            end
            S_LOAD_W: begin
                busy = 1'b1;
                if (cnt_q < CNT_W'(ARRAY_SIZE)) begin
                    wbuf_rd_en   = 1'b1;
                    wbuf_rd_addr = wbase_q + ADDR_W'(cnt_q);
                end
                // Buffer read data arrives one cycle later, hence row k-1.
                if (cnt_q != '0) begin
                    arr_weight_load = 1'b1;
                    arr_weight_row  = ROW_W'(cnt_q - CNT_W'(1));
                end
                if (cnt_q == CNT_W'(ARRAY_SIZE)) begin
                    state_d = (num_vec_q == '0) ? S_DONE : S_COMPUTE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPUTE: begin
                busy        = 1'b1;
                act_rd_addr = abase_q + ADDR_W'(v_q);
                if (!stall) begin
                    en        = 1'b1;
                    act_rd_en = 1'b1;
                    v_d       = v_q + VEC_W'(1);
                    ecnt_d    = ecnt_q + ECNT_W'(1);
                    if (v_q == num_vec_q - VEC_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!stall) begin
                    en     = 1'b1;
                    ecnt_d = ecnt_q + ECNT_W'(1);
                    if (ecnt_q == ecnt_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign arr_enable = en;
    assign res_valid  = en && (ecnt_q >= res_first) && (ecnt_q <= res_last);
    assign res_idx    = res_valid ? VEC_W'(ecnt_q - res_first) : '0;

endmodule

// File: tb/tb_ternary_array_sequencer.sv
// Directed bench for ternary_array_sequencer: per-cycle captures of whole
// tile jobs checked against a table of hand-computed output vectors.
module tb_ternary_array_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wen;
        logic [11:0] waddr;
        logic        wl;
        logic [2:0]  row;
        logic        aen;
        logic [11:0] aaddr;
        logic        en;
        logic        rv;
        logic [9:0]  ridx;
    } obs_t;

    typedef struct {
        int   scn;
        int   cyc;
        obs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        stall = 1'b0;
    logic [9:0]  num_vec = '0;
    logic [11:0] wbase = '0;
    logic [11:0] abase = '0;
    logic        busy, done, wbuf_rd_en, arr_weight_load, act_rd_en;
    logic        arr_enable, res_valid;
    logic [11:0] wbuf_rd_addr, act_rd_addr;
    logic [2:0]  arr_weight_row;
    logic [9:0]  res_idx;

    int   errors = 0;
    int   checks = 0;
    obs_t cap [1:6][0:63];
    int   first_done [1:6];
    int   rv_cnt [1:6];
    int   aen_cnt [1:6];
    int   en_cnt [1:6];
    vec_t vecs [$];

    ternary_array_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
        .num_vec(num_vec), .wbase(wbase), .abase(abase),
        .busy(busy), .done(done),
        .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr),
        .arr_weight_load(arr_weight_load), .arr_weight_row(arr_weight_row),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .arr_enable(arr_enable), .res_valid(res_valid), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic b, logic d, logic we, logic [11:0] wa,
                                logic wl, logic [2:0] r, logic ae,
                                logic [11:0] aa, logic e, logic rv,
                                logic [9:0] ri);
        obs_t o;
        o = '{b, d, we, wa, wl, r, ae, aa, e, rv, ri};
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(busy, done, wbuf_rd_en, wbuf_rd_addr, arr_weight_load,
                  arr_weight_row, act_rd_en, act_rd_addr, arr_enable,
                  res_valid, res_idx);
    endfunction

    task automatic add(input int s, input int c, input obs_t e);
        vec_t v;
        v.scn = s; v.cyc = c; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Issues a start, then captures 64 cycles; cycle 0 is the first LOAD_W cycle.
    task automatic run_scn(input int scn, input int nv, input int wb,
                           input int ab, input int stl, input int sth,
                           input int abc, input int rsc, input int s1,
                           input int s2);
        obs_t o;
        first_done[scn] = -1;
        rv_cnt[scn] = 0; aen_cnt[scn] = 0; en_cnt[scn] = 0;
        num_vec = 10'(nv); wbase = 12'(wb); abase = 12'(ab);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            stall = (c >= stl) && (c <= sth);
            abort = (c == abc);
            start = (c == s1) || (c == s2);
            if (c == rsc) rst = 1'b1;
            if (c == rsc + 1) rst = 1'b0;
            @(negedge clk);
            o = sample();
            cap[scn][c] = o;
            if (o.done && first_done[scn] < 0) first_done[scn] = c;
            if (o.rv) rv_cnt[scn]++;
            if (o.aen) aen_cnt[scn]++;
            if (o.en) en_cnt[scn]++;
            @(posedge clk); #1;
        end
        stall = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        obs_t z;
        obs_t o;
        z = '0;

        // scenario 1: reset mid-job
        add(1, 11, mk(1,0,0,12'h000,0,3'd0,1,12'h042,1,0,10'd0));
        add(1, 12, z);
        add(1, 13, z);
        add(1, 20, z);
        // scenario 2: num_vec=4, wbase=0x010, abase=0x040
        add(2, 0,  mk(1,0,1,12'h010,0,3'd0,0,12'h000,0,0,10'd0));
        add(2, 1,  mk(1,0,1,12'h011,1,3'd0,0,12'h000,0,0,10'd0));
        add(2, 7,  mk(1,0,1,12'h017,1,3'd6,0,12'h000,0,0,10'd0));
        add(2, 8,  mk(1,0,0,12'h000,1,3'd7,0,12'h000,0,0,10'd0));
        add(2, 9,  mk(1,0,0,12'h000,0,3'd0,1,12'h040,1,0,10'd0));
        add(2, 12, mk(1,0,0,12'h000,0,3'd0,1,12'h043,1,0,10'd0));
        add(2, 13, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(2, 17, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(2, 18, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,1,10'd0));
        add(2, 21, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,1,10'd3));
        add(2, 22, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(2, 28, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(2, 29, mk(0,1,0,12'h000,0,3'd0,0,12'h000,0,0,10'd0));
        add(2, 30, z);
        // scenario 3: stall at cycles 10..12
        add(3, 10, mk(1,0,0,12'h000,0,3'd0,0,12'h041,0,0,10'd0));
        add(3, 12, mk(1,0,0,12'h000,0,3'd0,0,12'h041,0,0,10'd0));
        add(3, 13, mk(1,0,0,12'h000,0,3'd0,1,12'h041,1,0,10'd0));
        add(3, 15, mk(1,0,0,12'h000,0,3'd0,1,12'h043,1,0,10'd0));
        add(3, 16, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(3, 21, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,1,10'd0));
        add(3, 24, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,1,10'd3));
        add(3, 25, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(3, 31, mk(1,0,0,12'h000,0,3'd0,0,12'h000,1,0,10'd0));
        add(3, 32, mk(0,1,0,12'h000,0,3'd0,0,12'h000,0,0,10'd0));
        // scenario 4: abort at cycle 20, restart at cycle 21
        add(4, 21, z);
        add(4, 22, mk(1,0,1,12'h010,0,3'd0,0,12'h000,0,0,10'd0));
        add(4, 31, mk(1,0,0,12'h000,0,3'd0,1,12'h040,1,0,10'd0));
        add(4, 51, mk(0,1,0,12'h000,0,3'd0,0,12'h000,0,0,10'd0));
        // scenario 5: num_vec=0 with wrapping weight addresses
        add(5, 0,  mk(1,0,1,12'hFFE,0,3'd0,0,12'h000,0,0,10'd0));
        add(5, 1,  mk(1,0,1,12'hFFF,1,3'd0,0,12'h000,0,0,10'd0));
        add(5, 2,  mk(1,0,1,12'h000,1,3'd1,0,12'h000,0,0,10'd0));
        add(5, 7,  mk(1,0,1,12'h005,1,3'd6,0,12'h000,0,0,10'd0));
        add(5, 8,  mk(1,0,0,12'h000,1,3'd7,0,12'h000,0,0,10'd0));
        add(5, 9,  mk(0,1,0,12'h000,0,3'd0,0,12'h000,0,0,10'd0));
        add(5, 10, z);
        // scenario 6: start during LOAD_W and during DONE is ignored
        add(6, 5,  mk(1,0,1,12'h015,1,3'd4,0,12'h000,0,0,10'd0));
        add(6, 29, mk(0,1,0,12'h000,0,3'd0,0,12'h000,0,0,10'd0));
        add(6, 30, z);
        add(6, 40, z);

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        o = sample();
        checks++;
        if (o != z) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", o, z);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_scn(1, 4, 12'h010, 12'h040, -1, -1, -1, 12, -1, -1);
        run_scn(2, 4, 12'h010, 12'h040, -1, -1, -1, -1, -1, -1);
        run_scn(3, 4, 12'h010, 12'h040, 10, 12, -1, -1, -1, -1);
        run_scn(4, 4, 12'h010, 12'h040, -1, -1, 20, -1, 21, -1);
        run_scn(5, 0, 12'hFFE, 12'h100, -1, -1, -1, -1, -1, -1);
        run_scn(6, 4, 12'h010, 12'h040, -1, -1, -1, -1, 5, 29);

        foreach (vecs[i]) begin
            checks++;
            if (cap[vecs[i].scn][vecs[i].cyc] != vecs[i].exp) begin
                errors++;
                $display("FAIL scn%0d_cyc%0d got=%h exp=%h", vecs[i].scn,
                         vecs[i].cyc, cap[vecs[i].scn][vecs[i].cyc],
                         vecs[i].exp);
            end
        end

        check_int("scn1_done_cycle", first_done[1], -1);
        check_int("scn2_done_cycle", first_done[2], 29);
        check_int("scn2_res_valid_count", rv_cnt[2], 4);
        check_int("scn2_act_rd_count", aen_cnt[2], 4);
        check_int("scn2_enable_count", en_cnt[2], 20);
        check_int("scn3_done_cycle", first_done[3], 32);
        check_int("scn3_res_valid_count", rv_cnt[3], 4);
        check_int("scn3_enable_count", en_cnt[3], 20);
        check_int("scn4_done_cycle", first_done[4], 51);
        check_int("scn5_done_cycle", first_done[5], 9);
        check_int("scn5_act_rd_count", aen_cnt[5], 0);
        check_int("scn5_res_valid_count", rv_cnt[5], 0);
        check_int("scn6_done_cycle", first_done[6], 29);
        check_int("scn6_enable_count", en_cnt[6], 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
